// File: rtl/nn_para_pkg.sv
// Shared word, vector and state definitions for the NN parallel host sequencer.
package nn_para_pkg;

    localparam int unsigned inte_width = 2;
    localparam int unsigned sign_bit   = 1;
    localparam int unsigned frac_width = 5;
    localparam int unsigned W          = inte_width + sign_bit + frac_width;
    localparam int unsigned N          = 4;
    localparam int unsigned unit_num   = 3;

    typedef logic signed [W-1:0] word_t;
    typedef word_t [N-1:0]        vec_t;
    typedef word_t [unit_num-1:0] res_t;

    typedef logic [1:0] state_t;
    localparam state_t LOAD  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t DRAIN = 2'd3;

endpackage

// File: rtl/nn_result_ser.sv
// Captures the NN core result vector on a load strobe and streams it out
// word by word with valid/ready/last, pulsing done on the last handshake.
module nn_result_ser
    import nn_para_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [unit_num*W-1:0]     res,
    input  logic                      ready,
    output logic                      valid,
    output logic signed [W-1:0]       data,
    output logic                      last,
    output logic                      done
);

    localparam int unsigned IW = $clog2(unit_num);

    res_t          res_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;
    logic          is_last;

    assign is_last = (idx_q == IW'(unit_num - 1));

    // Capture on load, then advance one word per accepted handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            res_q   <= res;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready) begin
            if (is_last) begin
                valid_q <= 1'b0;
                idx_q   <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Outputs are forced to zero while idle so stale results never leak out.
    always_comb begin
        valid = valid_q;
        data  = valid_q ? res_q[idx_q] : '0;
        last  = valid_q && is_last;
        done  = valid_q && ready && is_last;
    end

endmodule

// File: rtl/nn_para_host_seq.sv
// Host-side sequencer for the parallel NN core: assembles x1/b1 from a serial
// word stream, pulses nn_start, waits for nn_done (with timeout), then drains
// the captured result vector as a serial stream.
module nn_para_host_seq
    import nn_para_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [W-1:0]       in_data,
    output logic                      in_ready,
    output logic signed [N*W-1:0]     x1,
    output logic signed [W-1:0]       b1,
    output logic                      nn_start,
    input  logic                      nn_done,
    input  logic [unit_num*W-1:0]     nn_result,
    output logic                      out_valid,
    output logic signed [W-1:0]       out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    vec_t          x1_q;
    word_t         b1_q;
    logic [TW-1:0] timer_q;
    logic          timeout_err_q;
    logic          accept;
    logic          res_load;
    logic          ser_done;

    assign accept   = in_valid && (state_q == LOAD);
    // nn_done only matters while waiting; elsewhere it is ignored.
    assign res_load = (state_q == WAIT) && nn_done;

    // Main sequencing FSM with input assembly and WAIT timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= LOAD;
            cnt_q         <= '0;
            x1_q          <= '0;
            b1_q          <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (cnt_q == '0) timeout_err_q <= 1'b0;
                        if (cnt_q == CW'(N)) begin
                            b1_q    <= in_data;
                            cnt_q   <= '0;
                            state_q <= START;
                        end else begin
                            for (int i = 0; i < int'(N); i++) begin
                                if (cnt_q == CW'(i)) x1_q[i] <= in_data;
                            end
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                START: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (nn_done) begin
                        timer_q <= '0;
                        state_q <= DRAIN;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        timer_q       <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= LOAD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (ser_done) state_q <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // Registered-state decodes driving the host-side outputs.
    always_comb begin
        in_ready    = (state_q == LOAD);
        nn_start    = (state_q == START);
        busy        = (state_q != LOAD) || (cnt_q != '0);
        timeout_err = timeout_err_q;
        x1          = x1_q;
        b1          = b1_q;
    end

    nn_result_ser u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (res_load),
        .res   (nn_result),
        .ready (out_ready),
        .valid (out_valid),
        .data  (out_data),
        .last  (out_last),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_nn_para_host_seq.sv
// Self-checking bench for nn_para_host_seq with a stub NN core whose done
// arrives D cycles after it registers nn_start.
module tb_nn_para_host_seq;
    import nn_para_pkg::*;

    localparam int unsigned TMO = 16;
    localparam int          D   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic [W-1:0]          in_data = '0;
    logic                  in_ready;
    logic [N*W-1:0]        x1;
    logic [W-1:0]          b1;
    logic                  nn_start;
    logic                  nn_done;
    logic [unit_num*W-1:0] nn_result;
    logic                  out_valid;
    logic [W-1:0]          out_data;
    logic                  out_last;
    logic                  out_ready = 1'b1;
    logic                  busy;
    logic                  timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit exp_tmo = 1'b0;

    logic [7:0] words [5];
    logic [7:0] stub_res [3];
    bit stub_en = 1'b1;
    bit force_done = 1'b0;
    bit stub_act = 1'b0;
    int stub_cnt = 0;

    nn_para_host_seq #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .x1          (x1),
        .b1          (b1),
        .nn_start    (nn_start),
        .nn_done     (nn_done),
        .nn_result   (nn_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Stub core: registers start, then raises done D cycles later for one cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            stub_act <= 1'b0;
            stub_cnt <= 0;
        end else if (nn_start) begin
            stub_act <= 1'b1;
            stub_cnt <= 0;
        end else if (stub_act) begin
            if (stub_cnt == D) stub_act <= 1'b0;
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign nn_done   = (stub_en && stub_act && stub_cnt == D) || force_done;
    assign nn_result = {stub_res[2], stub_res[1], stub_res[0]};

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit gap, output int hs);
        hs = -1;
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 50; k++) begin
            chk("no_early_start", nn_start, 1'b0);
            if (in_ready) begin
                hs = cyc;
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 5; i++) words[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) stub_res[i] = 8'($urandom);
    endtask

    task automatic run_frame(input bit gaps, input bit bp, input bit no_done, input int abort_after);
        logic [7:0]     q[$];
        logic [N*W-1:0] ex1;
        int hs, first_v, got, bp_left, n;
        ex1 = {words[3], words[2], words[1], words[0]};
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(stub_res[i]);
        stub_en = !no_done;
        chk("tmo_before", timeout_err, exp_tmo);
        for (int i = 0; i < 5; i++) begin
            send_word(words[i], gaps, hs);
            if (i == 0) chk("tmo_clear", timeout_err, 1'b0);
        end
        exp_tmo = 1'b0;
        chk("x1_load", x1, ex1);
        chk("b1_load", b1, words[4]);
        first_v = -1;
        got     = 0;
        bp_left = bp ? 3 : 0;
        n       = 0;
        for (int k = 0; k < 200; k++) begin
            out_ready = !(bp && got == 1 && bp_left > 0);
            if (nn_start) n++;
            if (no_done && in_ready) break;
            chk("in_ready_low", in_ready, 1'b0);
            chk("busy_high", busy, 1'b1);
            chk("x1_stable", x1, ex1);
            chk("b1_stable", b1, words[4]);
            if (no_done) chk("no_valid", out_valid, 1'b0);
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (q.size() == 0) begin
                    chk("extra_word", out_valid, 1'b0);
                end else if (out_ready) begin
                    chk("out_data", out_data, q[0]);
                    void'(q.pop_front());
                    chk("out_last", out_last, q.size() == 0);
                    got++;
                end else begin
                    chk("bp_data", out_data, q[0]);
                    chk("bp_last", out_last, q.size() == 1);
                    bp_left--;
                end
            end
            tick();
            if (abort_after >= 0 && got == abort_after) begin
                out_ready = 1'b1;
                return;
            end
            if (got == 3) break;
        end
        out_ready = 1'b1;
        chk("start_count", n, 1);
        if (no_done) begin
            chk("tmo_cycle", cyc, hs + 2 + int'(TMO));
            chk("tmo_flag", timeout_err, 1'b1);
            exp_tmo = 1'b1;
        end else begin
            chk("words_got", got, 3);
            chk("latency", first_v, hs + D + 3);
            chk("idle_ready", in_ready, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_valid", out_valid, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_data"}, out_data, 8'h00);
        chk({tag, "_last"}, out_last, 1'b0);
        chk({tag, "_start"}, nn_start, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_tmo"}, timeout_err, 1'b0);
        chk({tag, "_x1"}, x1, 32'h0);
        chk({tag, "_b1"}, b1, 8'h00);
        chk({tag, "_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) stub_res[i] = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Directed single frame.
        words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h30; words[3] = 8'h30;
        words[4] = 8'h00;
        stub_res[0] = 8'h10; stub_res[1] = 8'h20; stub_res[2] = 8'h30;
        run_frame(1'b0, 1'b0, 1'b0, -1);

        // Input gaps.
        rand_frame();
        run_frame(1'b1, 1'b0, 1'b0, -1);

        // Backpressure on word 1.
        rand_frame();
        stub_res[1] = 8'h20;
        run_frame(1'b0, 1'b1, 1'b0, -1);

        // Timeout, then a normal frame that clears the flag.
        rand_frame();
        run_frame(1'b0, 1'b0, 1'b1, -1);
        repeat (8) tick();
        rand_frame();
        run_frame(1'b0, 1'b0, 1'b0, -1);

        // Reset after word 0 of DRAIN.
        rand_frame();
        run_frame(1'b0, 1'b0, 1'b0, 1);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n   = 1'b1;
        exp_tmo = 1'b0;
        tick();
        rand_frame();
        run_frame(1'b0, 1'b0, 1'b0, -1);

        // Spurious done while idle must not capture or emit anything.
        for (int i = 0; i < 3; i++) stub_res[i] = 8'($urandom);
        force_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("spur_valid", out_valid, 1'b0);
            chk("spur_ready", in_ready, 1'b1);
            chk("spur_busy", busy, 1'b0);
            tick();
        end
        force_done = 1'b0;
        rand_frame();
        run_frame(1'b0, 1'b0, 1'b0, -1);

        // Random frames with random gaps and backpressure.
        for (int r = 0; r < 4; r++) begin
            rand_frame();
            run_frame(1'($urandom), 1'($urandom), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
